// File: rtl/cpu6502_pkg.sv
// Shared definitions for the 6502 interrupt/reset entry sequencer.
//   int_type_t  : kind of entry sequence currently being stepped
//   seq_step_t  : 3-bit step index, STEP_OPC (0) .. STEP_VECH (6)
//   DEF_*_VEC   : default vector low-byte addresses
//   seq_state_t : sequencer FSM states
package cpu6502_pkg;

    typedef enum logic [2:0] {
        INT_NONE,
        INT_RES,
        INT_NMI,
        INT_BRK,
        INT_IRQ
    } int_type_t;

    typedef logic [2:0] seq_step_t;

    localparam seq_step_t STEP_OPC   = 3'd0;  // opcode or forced-BRK fetch
    localparam seq_step_t STEP_DUMMY = 3'd1;  // dummy read
    localparam seq_step_t STEP_PCH   = 3'd2;  // push PCH
    localparam seq_step_t STEP_PCL   = 3'd3;  // push PCL
    localparam seq_step_t STEP_P     = 3'd4;  // push P
    localparam seq_step_t STEP_VECL  = 3'd5;  // vector low fetch
    localparam seq_step_t STEP_VECH  = 3'd6;  // vector high fetch

    localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
    localparam logic [15:0] DEF_RES_VEC = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VEC = 16'hFFFE;

    typedef enum logic {
        ST_IDLE,
        ST_SEQ
    } seq_state_t;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for asynchronous pins.
//   clk    in        capture clock
//   rst_n  in        asynchronous active-low reset, all stages load RST_VAL
//   d      in WIDTH  asynchronous inputs
//   q      out WIDTH synchronised outputs, STAGES clocks behind d
module sync_ff_chain
    import cpu6502_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/cpu_6502_int_seq.sv
// Interrupt/reset entry sequencer for the 6502 core.
// Synchronises IRQ/NMI, latches NMI falling edges, arbitrates RESET > NMI > BRK > IRQ
// at opcode-fetch boundaries and steps the 7-cycle entry sequence.
// Ports:
//   clk, res (async active-low reset), rdy (low stalls read cycles)
//   irq_n (level), nmi_n (falling edge), i_flag (P.I), sync, brk_op
//   force_brk, int_active, step[2:0], stack_wr, b_flag, set_i,
//   vec_addr[15:0], seq_done
// The sequence is entered on the clock edge that samples sync (or the first edge
// after reset release); step 0 is the following cycle. All outputs decode from
// registered state only, so they hold whenever the state holds.
module cpu_6502_int_seq
    import cpu6502_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] NMI_VEC     = DEF_NMI_VEC,
    parameter logic [15:0] RES_VEC     = DEF_RES_VEC,
    parameter logic [15:0] IRQ_VEC     = DEF_IRQ_VEC
) (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        irq_n,
    input  logic        nmi_n,
    input  logic        i_flag,
    input  logic        sync,
    input  logic        brk_op,
    output logic        force_brk,
    output logic        int_active,
    output logic [2:0]  step,
    output logic        stack_wr,
    output logic        b_flag,
    output logic        set_i,
    output logic [15:0] vec_addr,
    output logic        seq_done
);

    logic [1:0]  pins_sync;
    logic        irq_sync, nmi_sync;
    logic        nmi_edge, irq_act, in_seq, wr_cyc, advance, nmi_clr;
    int_type_t   pick;
    logic [15:0] vec_base;

    seq_state_t  state_q, state_d;
    seq_step_t   step_q, step_d;
    int_type_t   type_q, type_d;
    logic        b_q, b_d;
    logic        force_q, force_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        res_pend_q, res_pend_d;
    logic        nmi_prev_q, nmi_prev_d;

    sync_ff_chain #(
        .WIDTH   (2),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (2'b11)
    ) u_pin_sync (
        .clk   (clk),
        .rst_n (res),
        .d     ({irq_n, nmi_n}),
        .q     (pins_sync)
    );

    assign irq_sync = pins_sync[1];
    assign nmi_sync = pins_sync[0];

    assign nmi_edge = nmi_prev_q & ~nmi_sync;
    assign irq_act  = ~irq_sync & ~i_flag;
    assign in_seq   = (state_q == ST_SEQ);
    // RESET performs its stack cycles as reads, so only other types write.
    assign wr_cyc   = in_seq && (type_q != INT_RES) &&
                      (step_q inside {STEP_PCH, STEP_PCL, STEP_P});
    // Write cycles ignore RDY, exactly like the real 6502.
    assign advance  = rdy | wr_cyc;
    assign pick     = nmi_pend_q ? INT_NMI :
                      brk_op     ? INT_BRK :
                      irq_act    ? INT_IRQ : INT_NONE;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        type_d     = type_q;
        b_d        = b_q;
        force_d    = force_q;
        res_pend_d = res_pend_q;
        nmi_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (res_pend_q) begin
                    state_d    = ST_SEQ;
                    step_d     = STEP_OPC;
                    type_d     = INT_RES;
                    b_d        = 1'b0;
                    force_d    = 1'b0;
                    res_pend_d = 1'b0;
                end else if (sync && (pick != INT_NONE)) begin
                    state_d = ST_SEQ;
                    step_d  = STEP_OPC;
                    type_d  = pick;
                    b_d     = (pick == INT_BRK);
                    force_d = (pick != INT_BRK);
                end
            end
            ST_SEQ: begin
                // NMI hijack: an NMI arriving before the vector fetch redirects
                // an IRQ/BRK entry; the already-chosen B value is kept.
                if (((type_q == INT_IRQ) || (type_q == INT_BRK)) &&
                    (step_q <= STEP_P) && (nmi_pend_q | nmi_edge)) begin
                    type_d = INT_NMI;
                end
                if (advance) begin
                    if (step_q == STEP_VECH) begin
                        state_d = ST_IDLE;
                        step_d  = STEP_OPC;
                    end else begin
                        step_d = seq_step_t'(step_q + 3'd1);
                    end
                    if ((type_q == INT_NMI) && (step_q == STEP_VECL)) begin
                        nmi_clr = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh edge wins over the clear so an NMI during NMI entry is not lost.
    assign nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_edge;
    assign nmi_prev_d = nmi_sync;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= ST_IDLE;
            step_q     <= STEP_OPC;
            type_q     <= INT_NONE;
            b_q        <= 1'b0;
            force_q    <= 1'b0;
            nmi_pend_q <= 1'b0;
            res_pend_q <= 1'b1;
            nmi_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            type_q     <= type_d;
            b_q        <= b_d;
            force_q    <= force_d;
            nmi_pend_q <= nmi_pend_d;
            res_pend_q <= res_pend_d;
            nmi_prev_q <= nmi_prev_d;
        end
    end

    assign vec_base = (type_q == INT_NMI) ? NMI_VEC :
                      (type_q == INT_RES) ? RES_VEC : IRQ_VEC;

    assign int_active = in_seq;
    assign step       = in_seq ? step_q : 3'd0;
    assign force_brk  = in_seq && (step_q == STEP_OPC) && force_q;
    assign stack_wr   = wr_cyc;
    assign b_flag     = in_seq & b_q;
    assign set_i      = in_seq && (step_q == STEP_VECL);
    assign seq_done   = in_seq && (step_q == STEP_VECH);
    assign vec_addr   = (in_seq && ((step_q == STEP_VECL) || (step_q == STEP_VECH))) ?
                        ((vec_base & 16'hFFFE) | {15'd0, step_q == STEP_VECH}) : 16'h0000;

endmodule

// File: tb/tb_cpu_6502_int_seq.sv
// Scoreboard bench for cpu_6502_int_seq: stimulus pushes the expected per-cycle
// output record of each entry sequence; the monitor pops and compares one record
// on every cycle the DUT reports int_active.
module tb_cpu_6502_int_seq;

    logic        clk = 1'b0;
    logic        res, rdy, irq_n, nmi_n, i_flag, sync, brk_op;
    logic        force_brk, int_active, stack_wr, b_flag, set_i, seq_done;
    logic [2:0]  step;
    logic [15:0] vec_addr;

    int tests   = 0;
    int fails   = 0;
    int entries = 0;
    logic [23:0] exp_q [$];

    always #5 clk = ~clk;

    cpu_6502_int_seq dut (
        .clk        (clk),
        .res        (res),
        .rdy        (rdy),
        .irq_n      (irq_n),
        .nmi_n      (nmi_n),
        .i_flag     (i_flag),
        .sync       (sync),
        .brk_op     (brk_op),
        .force_brk  (force_brk),
        .int_active (int_active),
        .step       (step),
        .stack_wr   (stack_wr),
        .b_flag     (b_flag),
        .set_i      (set_i),
        .vec_addr   (vec_addr),
        .seq_done   (seq_done)
    );

    // Record layout: {force_brk, stack_wr, b_flag, set_i, seq_done, step, vec_addr}
    function automatic logic [23:0] mk(input int s, input bit wr, input bit b,
                                       input bit forced, input logic [15:0] base);
        logic [15:0] v;
        v = (s == 5) ? base : (s == 6) ? base + 16'd1 : 16'h0000;
        return {(forced && s == 0), (wr && s >= 2 && s <= 4), b, (s == 5), (s == 6), 3'(s), v};
    endfunction

    task automatic push_seq(input bit wr, input bit b, input bit forced, input logic [15:0] base,
                            input int stall_step, input int stall_n, input int last_step);
        for (int s = 0; s <= last_step; s++) begin
            int reps;
            reps = (s == stall_step) ? 1 + stall_n : 1;
            for (int r = 0; r < reps; r++) exp_q.push_back(mk(s, wr, b, forced, base));
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, int_active, force_brk, stack_wr, b_flag, set_i, seq_done, step, vec_addr};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [23:0] got, e;
        logic        prev_act;
        logic [2:0]  prev_step;
        prev_act  = 1'b0;
        prev_step = 3'd0;
        forever begin
            @(negedge clk);
            if (int_active === 1'b1) begin
                got = {force_brk, stack_wr, b_flag, set_i, seq_done, step, vec_addr};
                if (step == 3'd0 && (!prev_act || prev_step != 3'd0)) entries++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_entry got=%h required=idle", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        fails++;
                        $display("FAIL seq_rec got=%h required=%h", got, e);
                    end
                end
            end
            prev_act  = (int_active === 1'b1);
            prev_step = step;
        end
    end

    task automatic wait_step(input int s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(int_active === 1'b1 && step == 3'(s)) && n < 40);
        tests++;
        if (!(int_active === 1'b1 && step == 3'(s))) begin
            fails++;
            $display("FAIL wait_step%0d got=timeout required=step_reached", s);
        end
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int_active !== 1'b0 && n < 40);
        tests++;
        if (int_active !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle got=timeout required=idle");
        end
        #2;
    endtask

    task automatic do_sync(input bit b);
        @(negedge clk); #2;
        sync   = 1'b1;
        brk_op = b;
        @(negedge clk); #2;
        sync   = 1'b0;
        brk_op = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        res = 1'b0; rdy = 1'b1; irq_n = 1'b1; nmi_n = 1'b1;
        i_flag = 1'b1; sync = 1'b0; brk_op = 1'b0;

        // 1: power-on reset, then RESET sequence FFFC/FFFD with no writes
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", all_outs(), 32'h0);
        end
        #2;
        push_seq(1'b0, 1'b0, 1'b0, 16'hFFFC, -1, 0, 6);
        res = 1'b1;
        wait_idle();
        check("reset_entry_count", entries, 1);

        // 2: NMI held low, syncs every 4 cycles -> exactly one entry
        nmi_n = 1'b0;
        gap(4);
        push_seq(1'b1, 1'b0, 1'b1, 16'hFFFA, -1, 0, 6);
        for (int k = 0; k < 6; k++) begin
            do_sync(1'b0);
            gap(2);
        end
        check("nmi_single_entry", entries, 2);
        nmi_n = 1'b1;
        gap(3);

        // 3: IRQ masked by I over 10 syncs, then unmasked
        irq_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            do_sync(1'b0);
            gap(2);
        end
        check("irq_masked_no_entry", entries, 2);
        i_flag = 1'b0;
        push_seq(1'b1, 1'b0, 1'b1, 16'hFFFE, -1, 0, 6);
        do_sync(1'b0);
        i_flag = 1'b1;
        wait_idle();
        check("irq_entry_count", entries, 3);
        irq_n = 1'b1;
        gap(3);

        // 4: BRK hijacked by an NMI edge that becomes visible at step 3
        push_seq(1'b1, 1'b1, 1'b0, 16'hFFFA, -1, 0, 6);
        do_sync(1'b1);
        wait_step(1);
        nmi_n = 1'b0;
        wait_idle();
        check("brk_entry_count", entries, 4);
        do_sync(1'b0);
        gap(3);
        check("nmi_pend_cleared", entries, 4);
        nmi_n = 1'b1;
        gap(3);

        // 5a: IRQ with rdy low for 5 cycles at step 1 -> step 1 holds
        irq_n = 1'b0;
        gap(3);
        i_flag = 1'b0;
        push_seq(1'b1, 1'b0, 1'b1, 16'hFFFE, 1, 5, 6);
        do_sync(1'b0);
        i_flag = 1'b1;
        wait_step(1);
        rdy = 1'b0;
        gap(5);
        rdy = 1'b1;
        wait_idle();
        check("stall_read_entry_count", entries, 5);

        // 5b: rdy low across write steps 3/4 -> steps still advance
        i_flag = 1'b0;
        push_seq(1'b1, 1'b0, 1'b1, 16'hFFFE, -1, 0, 6);
        do_sync(1'b0);
        i_flag = 1'b1;
        wait_step(3);
        rdy = 1'b0;
        gap(2);
        rdy = 1'b1;
        wait_idle();
        check("stall_write_entry_count", entries, 6);

        // 6: reset asserted at step 4 of IRQ entry, then full RESET sequence
        i_flag = 1'b0;
        push_seq(1'b1, 1'b0, 1'b1, 16'hFFFE, -1, 0, 4);
        do_sync(1'b0);
        i_flag = 1'b1;
        wait_step(4);
        res = 1'b0;
        #1;
        check("async_reset_clear", all_outs(), 32'h0);
        irq_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_hold_outputs", all_outs(), 32'h0);
        end
        #2;
        push_seq(1'b0, 1'b0, 1'b0, 16'hFFFC, -1, 0, 6);
        res = 1'b1;
        wait_idle();
        check("final_entry_count", entries, 8);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
